marker_pixel_detector: RTL and testbench
========================================

// Module: marker_pixel_detector
// PURPOSE
// - Front end of the marker tracker. Classifies a raster YCrCb pixel stream into 4 marker colours and emits
//   one (colour, x, y) event per accepted marker pixel for the downstream centroid/corner stage.
// - Generates frame_flag: high through vertical blanking, telling the centroid stage to close and
//   normalise its per-frame sums.
// - Per-colour Cr/Cb windows are run-time writable; a horizontal run-length filter suppresses noise.
// PARAMETERS
// - H_ACTIVE  640  active pixels per line; x >= H_ACTIVE is ignored
// - V_ACTIVE  480  active lines per frame; y >= V_ACTIVE is ignored
// - RUN_LEN   4    consecutive same-colour pixels in one line required before reporting (1..15)
// - Y_MIN     32   minimum luma for any classification (inclusive)
// PORTS
// - clk              in   1   system clock
// - reset            in   1   synchronous, active-high reset
// - frame_start      in   1   1-cycle pulse before the first line_start of a frame
// - line_start       in   1   1-cycle pulse before each line's first pixel
// - pixel_valid      in   1   pixel_{y,cr,cb} valid this cycle
// - pixel_y/cr/cb    in   8   luma / red-diff / blue-diff, unsigned
// - cfg_we           in   1   threshold write strobe
// - cfg_addr         in   4   [3:2]=colour, [1:0]: 0 cr_min, 1 cr_max, 2 cb_min, 3 cb_max
// - cfg_data         in   8   threshold value
// - color            out  2   colour of reported pixel
// - interesting_x    out  10  x of reported pixel
// - interesting_y    out  9   y of reported pixel
// - interesting_flag out  1   1-cycle strobe: color/x/y valid
// - frame_flag       out  1   level, high from frame end until next frame_start
// BEHAVIOUR
// - Reset: all outputs 0; x=0, y=0, first_line=1, synced=0, run counter 0, pipeline valids 0,
//   thresholds to defaults: c0 Cr[160,255] Cb[0,110]; c1 Cr[0,110] Cb[0,110];
//   c2 Cr[0,120] Cb[160,255]; c3 Cr[130,170] Cb[0,90].
// - synced: set by frame_start, cleared only by reset. While 0 all pixels ignored, no events, frame_flag stays 0
//   (reset mid-frame => silent until next frame_start).
// - Coordinates: frame_start -> first_line=1. line_start -> x=0; y=0 if first_line (clear it) else y+1 (saturating
//   at 511). Each pixel_valid uses current x, then x+1 (saturating at 1023).
// - Pipeline (pixel_valid to interesting_flag = 3 cycles):
//   S1 registers pixel+x+y+in_range; S2 classifies; S3 run filter and output registers.
// - Classify: colour k matches iff Y>=Y_MIN and cr_min<=Cr<=cr_max and cb_min<=Cb<=cb_max (inclusive);
//   lowest matching k wins; no match => "none". Inverted window (min>max) never matches.
// - Run filter: counter (4b, saturating at RUN_LEN) of consecutive S2 pixels with same colour k.
//   Reset to 0 by line_start; on "none" or out-of-range -> 0; on colour change -> 1.
//   Report (interesting_flag=1) when counter value after update >= RUN_LEN. Non-valid cycles do not break runs.
// - Out-of-range pixels (x>=H_ACTIVE or y>=V_ACTIVE) never reported, never counted.
// - frame_flag: set 1 cycle after S3 processes pixel (H_ACTIVE-1, V_ACTIVE-1), i.e. after its possible event;
//   cleared by frame_start. frame_start and set in same cycle: clear wins.
//   interesting_flag is never high while frame_flag is high; pixels arriving with frame_flag=1 are dropped.
// - Config: cfg_we writes one byte; applies to pixels classified in S2 from the following cycle.
//   Write coincident with a compare uses the old value.
// - Simultaneous line_start and pixel_valid: line_start applied first; pixel takes x=0, new y.
// STRUCTURE
// - Shared include marker_defs.vh: colour codes (0 RED, 1 GREEN, 2 BLUE, 3 YELLOW), cfg_addr field map,
//   default threshold constants, H_ACTIVE/V_ACTIVE defaults (shared with centroid stage).
// - Sub-module color_window_compare (Y,Cr,Cb + 4 bounds + Y_MIN -> match), instantiated 4x in S2.
// - Top holds coordinate counters, threshold regfile, run filter, frame_flag logic.
// TESTING
// - Reset, frame_start, line_start, 6 px Y=100 Cr=200 Cb=50 at x=10..15 (RUN_LEN=4) -> 3 events c=0,y=0,
//   x=13,14,15, each 3 cycles after its pixel_valid.
// - Same line: 3 red, 1 blue (Cr=50,Cb=200), 4 red -> events only at final red px; blue resets run.
// - cfg_we addr=4'b0100 data=120 (c1 cr_min=120) then green px Cr=100 Cb=50 x6 -> no events;
//   Cr=115 Y=20 -> no events (luma).
// - Full 640x480 frame, all red -> last event x=639 y=479, frame_flag=1 next cycle, stays high,
//   drops to 0 on frame_start.
// - Reset mid-line, then pixels without frame_start -> no events, frame_flag 0; after frame_start normal.
// - Pixels at x=640..650 of red -> no events; Cr=165 Cb=80 matches c0 and c3 -> color=0.

Source files
------------

// File: rtl/marker_pixel_detector_pkg.sv
// Shared marker definitions: colour codes, config address map, default thresholds
// and the raster geometry shared with the centroid stage.
package marker_pixel_detector_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_e;

    // cfg_addr[1:0] selects the bound; cfg_addr[3:2] selects the colour
    typedef enum logic [1:0] {
        CFG_CR_MIN = 2'd0,
        CFG_CR_MAX = 2'd1,
        CFG_CB_MIN = 2'd2,
        CFG_CB_MAX = 2'd3
    } cfg_field_e;

    localparam int NUM_COLORS       = 4;
    localparam int X_W              = 10;
    localparam int Y_W              = 9;
    localparam int RUN_W            = 4;
    localparam int DEFAULT_H_ACTIVE = 640;
    localparam int DEFAULT_V_ACTIVE = 480;
    localparam int DEFAULT_RUN_LEN  = 4;
    localparam int DEFAULT_Y_MIN    = 32;

    typedef struct packed {
        logic [7:0] cr_min;
        logic [7:0] cr_max;
        logic [7:0] cb_min;
        logic [7:0] cb_max;
    } window_t;

    function automatic window_t default_window(input color_e c);
        window_t w;
        case (c)
            RED:     w = '{cr_min: 8'd160, cr_max: 8'd255, cb_min: 8'd0,   cb_max: 8'd110};
            GREEN:   w = '{cr_min: 8'd0,   cr_max: 8'd110, cb_min: 8'd0,   cb_max: 8'd110};
            BLUE:    w = '{cr_min: 8'd0,   cr_max: 8'd120, cb_min: 8'd160, cb_max: 8'd255};
            default: w = '{cr_min: 8'd130, cr_max: 8'd170, cb_min: 8'd0,   cb_max: 8'd90};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/marker_pixel_detector_color_window_compare.sv
// Inclusive Cr/Cb window test with a luma floor; an inverted window (min > max)
// can never match.
module color_window_compare
    import marker_pixel_detector_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] cr,
    input  logic [7:0] cb,
    input  window_t    window,
    input  logic [7:0] y_min,
    output logic       match
);

    assign match = (y >= y_min)
                && (cr >= window.cr_min) && (cr <= window.cr_max)
                && (cb >= window.cb_min) && (cb <= window.cb_max);

endmodule

// File: rtl/marker_pixel_detector.sv
// Marker tracker front end: classifies a YCrCb raster into four colours, run-length
// filters each line and emits (colour, x, y) events plus an end-of-frame level.
module marker_pixel_detector
    import marker_pixel_detector_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
    parameter int RUN_LEN  = DEFAULT_RUN_LEN,
    parameter int Y_MIN    = DEFAULT_Y_MIN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_start,
    input  logic           line_start,
    input  logic           pixel_valid,
    input  logic [7:0]     pixel_y,
    input  logic [7:0]     pixel_cr,
    input  logic [7:0]     pixel_cb,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [7:0]     cfg_data,
    output logic [1:0]     color,
    output logic [X_W-1:0] interesting_x,
    output logic [Y_W-1:0] interesting_y,
    output logic           interesting_flag,
    output logic           frame_flag
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
    localparam logic [X_W:0]     X_LIMIT = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W:0]     Y_LIMIT = (Y_W + 1)'(V_ACTIVE);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [7:0]       Y_FLOOR = 8'(Y_MIN);

    window_t        windows [NUM_COLORS];
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           first_line;
    logic           synced;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;

    // line_start takes effect before a pixel arriving in the same cycle
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a default
        // first, so no path leaves a value held and no latch is inferred.
        cur_x = x;
        cur_y = y;
        if (line_start) begin
            cur_x = '0;
            if (first_line || frame_start) begin
                cur_y = '0;
            end else if (y != '1) begin
                cur_y = y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking '<=' so every register samples the
        // pre-edge value of its sources regardless of statement order.
        if (reset) begin
            x          <= '0;
            y          <= '0;
            first_line <= 1'b1;
            synced     <= 1'b0;
        end else begin
            if (frame_start) begin
                synced <= 1'b1;
            end
            if (line_start) begin
                first_line <= 1'b0;
            end else if (frame_start) begin
                first_line <= 1'b1;
            end
            y <= cur_y;
            if (pixel_valid && cur_x != '1) begin
                x <= cur_x + 1'b1;
            end else begin
                x <= cur_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: this small threshold table is reset explicitly because its contents
        // must come up as the documented defaults; large data memories would not be.
        if (reset) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                windows[c] <= default_window(color_e'(2'(c)));
            end
        end else if (cfg_we) begin
            case (cfg_field_e'(cfg_addr[1:0]))
                CFG_CR_MIN: windows[cfg_addr[3:2]].cr_min <= cfg_data;
                CFG_CR_MAX: windows[cfg_addr[3:2]].cr_max <= cfg_data;
                CFG_CB_MIN: windows[cfg_addr[3:2]].cb_min <= cfg_data;
                default:    windows[cfg_addr[3:2]].cb_max <= cfg_data;
            endcase
        end
    end

    logic           s1_valid, s1_new_line, s1_in_range;
    logic [7:0]     s1_y, s1_cr, s1_cb;
    logic [X_W-1:0] s1_x;
    logic [Y_W-1:0] s1_py;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_new_line <= 1'b0;
            s1_in_range <= 1'b0;
            s1_y        <= '0;
            s1_cr       <= '0;
            s1_cb       <= '0;
            s1_x        <= '0;
            s1_py       <= '0;
        end else begin
            s1_valid    <= pixel_valid && synced && !frame_flag;
            s1_new_line <= line_start;
            s1_in_range <= ({1'b0, cur_x} < X_LIMIT) && ({1'b0, cur_y} < Y_LIMIT);
            s1_y        <= pixel_y;
            s1_cr       <= pixel_cr;
            s1_cb       <= pixel_cb;
            s1_x        <= cur_x;
            s1_py       <= cur_y;
        end
    end

    logic [NUM_COLORS-1:0] match;
    logic                  class_hit;
    color_e                class_color;

    for (genvar k = 0; k < NUM_COLORS; k++) begin : g_cmp
        color_window_compare u_cmp (
            .y      (s1_y),
            .cr     (s1_cr),
            .cb     (s1_cb),
            .window (windows[k]),
            .y_min  (Y_FLOOR),
            .match  (match[k])
        );
    end

    // Scan from the top so the lowest-numbered matching colour wins
    always_comb begin
        class_hit   = 1'b0;
        class_color = RED;
        for (int k = NUM_COLORS - 1; k >= 0; k--) begin
            if (match[k]) begin
                class_hit   = 1'b1;
                class_color = color_e'(2'(k));
            end
        end
    end

    logic           s2_valid, s2_new_line, s2_in_range, s2_hit;
    color_e         s2_color;
    logic [X_W-1:0] s2_x;
    logic [Y_W-1:0] s2_py;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            s2_new_line <= 1'b0;
            s2_in_range <= 1'b0;
            s2_hit      <= 1'b0;
            s2_color    <= RED;
            s2_x        <= '0;
            s2_py       <= '0;
        end else begin
            s2_valid    <= s1_valid;
            s2_new_line <= s1_new_line;
            s2_in_range <= s1_in_range;
            s2_hit      <= class_hit;
            s2_color    <= class_color;
            s2_x        <= s1_x;
            s2_py       <= s1_py;
        end
    end

    logic [RUN_W-1:0] run_cnt, run_base, run_next;
    color_e           run_color;
    logic             report, s2_last, s3_last;

    // The line marker travels with the pipeline so the run clears exactly
    // between the last pixel of one line and the first of the next.
    always_comb begin
        run_base = s2_new_line ? '0 : run_cnt;
        run_next = run_base;
        if (s2_valid) begin
            if (!s2_hit || !s2_in_range) begin
                run_next = '0;
            end else if (run_base != '0 && s2_color == run_color) begin
                run_next = (run_base >= RUN_MAX) ? RUN_MAX : run_base + 1'b1;
            end else begin
                run_next = RUN_W'(1);
            end
        end
        report  = s2_valid && s2_hit && s2_in_range && (run_next >= RUN_MAX) && !frame_flag;
        s2_last = s2_valid && s2_in_range && (s2_x == X_LAST) && (s2_py == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt          <= '0;
            run_color        <= RED;
            s3_last          <= 1'b0;
            interesting_flag <= 1'b0;
            color            <= '0;
            interesting_x    <= '0;
            interesting_y    <= '0;
            frame_flag       <= 1'b0;
        end else begin
            run_cnt          <= run_next;
            s3_last          <= s2_last;
            interesting_flag <= report;
            if (s2_valid && s2_hit) begin
                run_color <= s2_color;
            end
            if (report) begin
                color         <= s2_color;
                interesting_x <= s2_x;
                interesting_y <= s2_py;
            end
            if (frame_start) begin
                frame_flag <= 1'b0;
            end else if (s3_last) begin
                frame_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_marker_pixel_detector.sv
// Directed bench for marker_pixel_detector: event positions, latency, run filter,
// threshold writes, range limits, colour priority, frame_flag and resync.
module tb_marker_pixel_detector;

    logic       clk = 1'b0;
    logic       reset, frame_start, line_start, pixel_valid;
    logic [7:0] pixel_y, pixel_cr, pixel_cb;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [1:0] color;
    logic [9:0] interesting_x;
    logic [8:0] interesting_y;
    logic       interesting_flag, frame_flag;

    typedef struct {
        int c;
        int x;
        int y;
        int t;
    } ev_t;

    ev_t ev_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  overlap  = 0;

    marker_pixel_detector dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .line_start       (line_start),
        .pixel_valid      (pixel_valid),
        .pixel_y          (pixel_y),
        .pixel_cr         (pixel_cr),
        .pixel_cb         (pixel_cb),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .color            (color),
        .interesting_x    (interesting_x),
        .interesting_y    (interesting_y),
        .interesting_flag (interesting_flag),
        .frame_flag       (frame_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Capture every reported event with the posedge count at which it became visible
    always @(negedge clk) begin
        ev_t e;
        if (interesting_flag) begin
            e.c = int'(color);
            e.x = int'(interesting_x);
            e.y = int'(interesting_y);
            e.t = cyc;
            ev_q.push_back(e);
        end
        if (interesting_flag && frame_flag) overlap++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] py, input logic [7:0] pcr, input logic [7:0] pcb,
                           output int t);
        pixel_valid = 1'b1;
        pixel_y     = py;
        pixel_cr    = pcr;
        pixel_cb    = pcb;
        t           = cyc;
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        int tt;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        n_checks++;
        if (interesting_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_flag: got %b expected 0", interesting_flag);
        end
        n_checks++;
        if (frame_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_flag: got %b expected 0", frame_flag);
        end
        n_checks++;
        if (color !== 2'd0) begin
            n_fail++; $display("FAIL reset_color: got %0d expected 0", color);
        end
        n_checks++;
        if (interesting_x !== 10'd0 || interesting_y !== 9'd0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0,0", interesting_x, interesting_y);
        end
        // Not yet synced: a full red run must be ignored
        ev_q.delete();
        pulse_line_start();
        for (int i = 0; i < 6; i++) send_px(8'd100, 8'd200, 8'd50, tt);
        idle(5);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL unsynced_events: got %0d expected 0", ev_q.size());
        end
    endtask

    task automatic test_basic_run();
        int t[6];
        int tt;
        ev_q.delete();
        pulse_frame_start();
        pulse_line_start();
        for (int i = 0; i < 10; i++) send_px(8'd0, 8'd128, 8'd128, tt);
        for (int i = 0; i < 6; i++) send_px(8'd100, 8'd200, 8'd50, t[i]);
        idle(5);
        n_checks++;
        if (ev_q.size() != 3) begin
            n_fail++; $display("FAIL basic_count: got %0d expected 3", ev_q.size());
        end
        for (int i = 0; i < 3 && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i].c != 0 || ev_q[i].x != 13 + i || ev_q[i].y != 0 || ev_q[i].t != t[3 + i] + 3) begin
                n_fail++;
                $display("FAIL basic_event%0d: got c=%0d x=%0d y=%0d t=%0d expected c=0 x=%0d y=0 t=%0d",
                         i, ev_q[i].c, ev_q[i].x, ev_q[i].y, ev_q[i].t, 13 + i, t[3 + i] + 3);
            end
        end
    endtask

    task automatic test_blue_break();
        int tt;
        int t_last;
        ev_q.delete();
        send_px(8'd0, 8'd128, 8'd128, tt);                              // x=16 breaks the run
        for (int i = 0; i < 3; i++) send_px(8'd100, 8'd200, 8'd50, tt); // x=17..19
        send_px(8'd100, 8'd50, 8'd200, tt);                             // x=20 blue
        for (int i = 0; i < 4; i++) send_px(8'd100, 8'd200, 8'd50, t_last); // x=21..24
        idle(5);
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL blue_break_count: got %0d expected 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].c != 0 || ev_q[0].x != 24 || ev_q[0].y != 0 || ev_q[0].t != t_last + 3) begin
                n_fail++;
                $display("FAIL blue_break_event: got c=%0d x=%0d y=%0d t=%0d expected c=0 x=24 y=0 t=%0d",
                         ev_q[0].c, ev_q[0].x, ev_q[0].y, ev_q[0].t, t_last + 3);
            end
        end
    endtask

    task automatic test_config();
        int tt;
        ev_q.delete();
        cfg_write(4'b0100, 8'd120);                                        // green cr_min=120 > cr_max
        pulse_line_start();                                                // y=1
        for (int i = 0; i < 6; i++) send_px(8'd100, 8'd100, 8'd50, tt);   // x=0..5
        for (int i = 0; i < 4; i++) send_px(8'd20, 8'd115, 8'd50, tt);    // x=6..9 luma too low
        for (int i = 0; i < 4; i++) send_px(8'd100, 8'd125, 8'd50, tt);   // x=10..13 inverted window
        idle(5);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL cfg_suppress: got %0d events expected 0", ev_q.size());
        end
        ev_q.delete();
        cfg_write(4'b0100, 8'd0);
        for (int i = 0; i < 4; i++) send_px(8'd100, 8'd100, 8'd50, tt);   // x=14..17
        idle(5);
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL cfg_restore_count: got %0d expected 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].c != 1 || ev_q[0].x != 17 || ev_q[0].y != 1) begin
                n_fail++;
                $display("FAIL cfg_restore_event: got c=%0d x=%0d y=%0d expected c=1 x=17 y=1",
                         ev_q[0].c, ev_q[0].x, ev_q[0].y);
            end
        end
    endtask

    task automatic test_range_priority();
        int tt;
        ev_q.delete();
        pulse_line_start();                                                // y=2
        for (int i = 0; i < 640; i++) send_px(8'd0, 8'd128, 8'd128, tt);
        for (int i = 0; i < 11; i++) send_px(8'd100, 8'd200, 8'd50, tt);  // x=640..650
        idle(5);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL out_of_range: got %0d events expected 0", ev_q.size());
        end
        ev_q.delete();
        pulse_line_start();                                                // y=3
        for (int i = 0; i < 4; i++) send_px(8'd100, 8'd165, 8'd80, tt);   // red and yellow both match
        idle(5);
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL priority_count: got %0d expected 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].c != 0 || ev_q[0].x != 3 || ev_q[0].y != 3) begin
                n_fail++;
                $display("FAIL priority_event: got c=%0d x=%0d y=%0d expected c=0 x=3 y=3",
                         ev_q[0].c, ev_q[0].x, ev_q[0].y);
            end
        end
    endtask

    task automatic test_full_frame();
        int tt;
        int t_last;
        ev_q.delete();
        overlap = 0;
        pulse_frame_start();
        for (int l = 0; l < 478; l++) pulse_line_start();                   // y=0..477, empty lines
        for (int l = 0; l < 2; l++) begin                                    // y=478, 479
            pulse_line_start();
            for (int i = 0; i < 640; i++) send_px(8'd100, 8'd200, 8'd50, t_last);
        end
        idle(2);                                                             // cyc = t_last+3
        n_checks++;
        if (interesting_flag !== 1'b1 || frame_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL last_event_cycle: got flag=%b frame_flag=%b expected 1,0", interesting_flag, frame_flag);
        end
        idle(1);                                                             // cyc = t_last+4
        n_checks++;
        if (frame_flag !== 1'b1) begin
            n_fail++; $display("FAIL frame_flag_set: got %b expected 1", frame_flag);
        end
        for (int i = 0; i < 3; i++) send_px(8'd100, 8'd200, 8'd50, tt);
        idle(6);
        n_checks++;
        if (frame_flag !== 1'b1) begin
            n_fail++; $display("FAIL frame_flag_hold: got %b expected 1", frame_flag);
        end
        n_checks++;
        if (ev_q.size() != 1274) begin
            n_fail++; $display("FAIL frame_event_count: got %0d expected 1274", ev_q.size());
        end
        if (ev_q.size() > 0) begin
            n_checks++;
            if (ev_q[$].c != 0 || ev_q[$].x != 639 || ev_q[$].y != 479 || ev_q[$].t != t_last + 3) begin
                n_fail++;
                $display("FAIL frame_last_event: got c=%0d x=%0d y=%0d t=%0d expected c=0 x=639 y=479 t=%0d",
                         ev_q[$].c, ev_q[$].x, ev_q[$].y, ev_q[$].t, t_last + 3);
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++; $display("FAIL flag_overlap: got %0d overlapping cycles expected 0", overlap);
        end
        pulse_frame_start();
        n_checks++;
        if (frame_flag !== 1'b0) begin
            n_fail++; $display("FAIL frame_flag_clear: got %b expected 0", frame_flag);
        end
    endtask

    task automatic test_reset_mid_line();
        int tt;
        int t[6];
        pulse_line_start();
        send_px(8'd100, 8'd200, 8'd50, tt);
        send_px(8'd100, 8'd200, 8'd50, tt);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        ev_q.delete();
        pulse_line_start();
        for (int i = 0; i < 6; i++) send_px(8'd100, 8'd200, 8'd50, tt);
        idle(5);
        n_checks++;
        if (ev_q.size() != 0 || frame_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL resync_silent: got %0d events frame_flag=%b expected 0 events, 0", ev_q.size(), frame_flag);
        end
        pulse_frame_start();
        pulse_line_start();
        for (int i = 0; i < 6; i++) send_px(8'd100, 8'd200, 8'd50, t[i]);
        idle(5);
        n_checks++;
        if (ev_q.size() != 3) begin
            n_fail++; $display("FAIL resync_count: got %0d expected 3", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].x != 3 || ev_q[0].y != 0 || ev_q[2].x != 5 || ev_q[2].t != t[5] + 3) begin
                n_fail++;
                $display("FAIL resync_events: got x0=%0d y0=%0d x2=%0d t2=%0d expected 3,0,5,%0d",
                         ev_q[0].x, ev_q[0].y, ev_q[2].x, ev_q[2].t, t[5] + 3);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        pixel_valid = 1'b0;
        pixel_y     = '0;
        pixel_cr    = '0;
        pixel_cb    = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_blue_break();
        test_config();
        test_range_priority();
        test_full_frame();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
